output_scan_driver: RTL and testbench

//  Parametrised time-multiplexed driver for a DIGITS-wide common-anode 7-segment bank: hex glyphs, per-digit dot and blank, optional leading-zero blanking.

---
 rtl/output_scan_driver.sv | 168 ++++++++++++++++
 tb/tb_output_scan_driver.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_scan_driver.sv
// output_scan_driver: time-multiplexed common-anode 7-segment scanner.
// Host data lands in a pending buffer and is copied to the shadow buffer
// only at the end of a full scan frame, so a frame is never torn.
// Outputs are registered and lag the prescaler/index by one cycle.
module output_scan_driver #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 50000,
  parameter int GAP      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dot_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  lzb_en,
  output logic                  loaded,
  output logic                  frame_start,
  output logic [0:7]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] GAP_V      = PW'(GAP);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  // Scan position
  logic [PW-1:0]          r_presc;
  logic [IW-1:0]          r_idx;

  // Pending (host side) buffer
  logic [4*DIGITS-1:0]    r_pend_bcd;
  logic [DIGITS-1:0]      r_pend_dot;
  logic [DIGITS-1:0]      r_pend_blank;
  logic                   r_pend_lzb;
  logic                   r_pend_valid;

  // Shadow (display side) buffer
  logic [4*DIGITS-1:0]    r_sh_bcd;
  logic [DIGITS-1:0]      r_sh_dot;
  logic [DIGITS-1:0]      r_sh_blank;
  logic                   r_sh_lzb;

  logic                   w_tick;
  logic                   w_commit;
  logic                   w_do_commit;
  logic                   w_lit;
  logic                   w_dark;
  logic                   w_run;
  logic [DIGITS-1:0]      w_lz_mask;
  logic [3:0]             w_nib;
  logic [0:6]             w_glyph;

  assign w_tick      = (r_presc == PRESC_LAST);
  assign w_commit    = w_tick && (r_idx == IDX_LAST);
  assign w_do_commit = w_commit && (r_pend_valid || load);
  assign w_lit       = (r_presc >= GAP_V);
  assign w_nib       = r_sh_bcd[{r_idx, 2'b00} +: 4];
  assign w_dark      = r_sh_blank[r_idx] | w_lz_mask[r_idx];

  // Leading-zero run: walks down from the leftmost digit; explicit blanks
  // do not influence the run, and digit 0 always stays visible.
  always_comb begin
    w_lz_mask = '0;
    w_run     = r_sh_lzb;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (w_run && (r_sh_bcd[4*k +: 4] == 4'h0) && !r_sh_dot[k]) begin
        w_lz_mask[k] = 1'b1;
      end else begin
        w_run = 1'b0;
      end
    end
  end

  // Hex glyph decode, active low, a..g left to right
  always_comb begin
    w_glyph = 7'b1111111;
    case (w_nib)
      4'h0: w_glyph = 7'b0000001;
      4'h1: w_glyph = 7'b1001111;
      4'h2: w_glyph = 7'b0010010;
      4'h3: w_glyph = 7'b0000110;
      4'h4: w_glyph = 7'b1001100;
      4'h5: w_glyph = 7'b0100100;
      4'h6: w_glyph = 7'b0100000;
      4'h7: w_glyph = 7'b0001111;
      4'h8: w_glyph = 7'b0000000;
      4'h9: w_glyph = 7'b0000100;
      4'hA: w_glyph = 7'b0001000;
      4'hB: w_glyph = 7'b1100000;
      4'hC: w_glyph = 7'b0110001;
      4'hD: w_glyph = 7'b1000010;
      4'hE: w_glyph = 7'b0110000;
      4'hF: w_glyph = 7'b0111000;
      default: w_glyph = 7'b1111111;
    endcase
  end

  // Prescaler and digit index advance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else begin
      if (w_tick) begin
        r_presc <= '0;
        r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  // Pending capture and frame-boundary commit into the shadow buffer;
  // a load in the commit cycle bypasses pending and is shown this frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_bcd   <= '0;
      r_pend_dot   <= '0;
      r_pend_blank <= '0;
      r_pend_lzb   <= 1'b0;
      r_pend_valid <= 1'b0;
      r_sh_bcd     <= '0;
      r_sh_dot     <= '0;
      r_sh_blank   <= '1;
      r_sh_lzb     <= 1'b0;
    end else begin
      if (load) begin
        r_pend_bcd   <= bcd_in;
        r_pend_dot   <= dot_in;
        r_pend_blank <= blank_in;
        r_pend_lzb   <= lzb_en;
      end
      if (w_do_commit) begin
        r_sh_bcd     <= load ? bcd_in   : r_pend_bcd;
        r_sh_dot     <= load ? dot_in   : r_pend_dot;
        r_sh_blank   <= load ? blank_in : r_pend_blank;
        r_sh_lzb     <= load ? lzb_en   : r_pend_lzb;
        r_pend_valid <= 1'b0;
      end else if (load) begin
        r_pend_valid <= 1'b1;
      end
    end
  end

  // Registered pin drive and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      seg         <= 8'hFF;
      an          <= '1;
      loaded      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= w_commit;
      loaded      <= w_do_commit;
      if (w_lit) begin
        an  <= ~(DIGITS'(1) << r_idx);
        seg <= w_dark ? 8'hFF : {w_glyph, ~r_sh_dot[r_idx]};
      end else begin
        an  <= '1;
        seg <= 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_output_scan_driver.sv
// Directed bench for output_scan_driver with DIGITS=4, SCAN_DIV=4, GAP=1.
// One frame = 16 cycles; each digit slot is 1 gap cycle + 3 lit cycles.
module tb_output_scan_driver;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int GAP      = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] bcd_in;
  logic [3:0]  dot_in;
  logic [3:0]  blank_in;
  logic        lzb_en;
  logic        loaded;
  logic        frame_start;
  logic [0:7]  seg;
  logic [3:0]  an;

  int total    = 0;
  int bad      = 0;
  int n_loaded = 0;

  logic [0:7] seg_cap[4];
  logic [3:0] an_cap[4];
  logic [0:7] gap_seg[4];
  logic [3:0] gap_an[4];
  logic       stable[4];
  logic [0:7] exp_seg[4];
  logic [3:0] exp_an;

  output_scan_driver #(
    .DIGITS  (DIGITS),
    .SCAN_DIV(SCAN_DIV),
    .GAP     (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .bcd_in     (bcd_in),
    .dot_in     (dot_in),
    .blank_in   (blank_in),
    .lzb_en     (lzb_en),
    .loaded     (loaded),
    .frame_start(frame_start),
    .seg        (seg),
    .an         (an)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1, "watchdog");
  end

  // One clock: inputs are driven and outputs sampled at the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (loaded === 1'b1) n_loaded++;
  endtask

  // Bounded wait for the frame_start pulse
  task automatic wait_fs();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (frame_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL wait_fs: frame_start=0 after 40 cycles, want 1");
    end
  endtask

  task automatic do_load(input logic [15:0] b, input logic [3:0] dt,
                         input logic [3:0] bl, input logic lz);
    bcd_in   = b;
    dot_in   = dt;
    blank_in = bl;
    lzb_en   = lz;
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  // Record one full frame, starting in the cycle frame_start was seen
  task automatic capture_frame();
    for (int d = 0; d < 4; d++) begin
      step();
      gap_an[d]  = an;
      gap_seg[d] = seg;
      step();
      an_cap[d]  = an;
      seg_cap[d] = seg;
      stable[d]  = 1'b1;
      repeat (2) begin
        step();
        if (an !== an_cap[d] || seg !== seg_cap[d]) stable[d] = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    total++;
    if (seg !== 8'hFF || an !== 4'b1111) begin
      bad++;
      $display("FAIL reset_pins: seg=%b an=%b, want seg=11111111 an=1111", seg, an);
    end
    total++;
    if (loaded !== 1'b0 || frame_start !== 1'b0) begin
      bad++;
      $display("FAIL reset_pulses: loaded=%b frame_start=%b, want 0 0", loaded, frame_start);
    end
    rst = 1'b0;
    step();
    total++;
    if (an !== 4'b1111) begin
      bad++;
      $display("FAIL reset_first_gap: an=%b, want 1111", an);
    end
    step();
    total++;
    if (an !== 4'b1110 || seg !== 8'hFF) begin
      bad++;
      $display("FAIL reset_first_lit: an=%b seg=%b, want an=1110 seg=11111111", an, seg);
    end
    wait_fs();
    capture_frame();
    exp_seg = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    for (int d = 0; d < 4; d++) begin
      exp_an = 4'b1111 ^ (4'b0001 << d);
      total++;
      if (gap_an[d] !== 4'b1111 || gap_seg[d] !== 8'hFF) begin
        bad++;
        $display("FAIL reset_gap d%0d: an=%b seg=%b, want 1111 11111111", d, gap_an[d], gap_seg[d]);
      end
      total++;
      if (an_cap[d] !== exp_an || seg_cap[d] !== exp_seg[d] || !stable[d]) begin
        bad++;
        $display("FAIL reset_slot d%0d: an=%b seg=%b stable=%b, want an=%b seg=%b stable=1",
                 d, an_cap[d], seg_cap[d], stable[d], exp_an, exp_seg[d]);
      end
    end
    total++;
    if (n_loaded !== 0) begin
      bad++;
      $display("FAIL reset_no_loaded: loaded pulses=%0d, want 0", n_loaded);
    end
  endtask

  task automatic test_load();
    int  n0;
    bit  dark_ok;
    bit  seen;
    repeat (3) step();
    n0 = n_loaded;
    do_load(16'h12AF, 4'b0000, 4'b0000, 1'b0);
    dark_ok = 1'b1;
    seen    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (seg !== 8'hFF) dark_ok = 1'b0;
      step();
      if (frame_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen || !dark_ok || seg !== 8'hFF) begin
      bad++;
      $display("FAIL load_no_tear: seen_fs=%b old_frame_dark=%b, want 1 1", seen, dark_ok);
    end
    total++;
    if (loaded !== 1'b1 || n_loaded - n0 !== 1) begin
      bad++;
      $display("FAIL load_pulse: loaded=%b pulses=%0d, want 1 1", loaded, n_loaded - n0);
    end
    capture_frame();
    exp_seg = '{8'b0111000_1, 8'b0001000_1, 8'b0010010_1, 8'b1001111_1};
    for (int d = 0; d < 4; d++) begin
      exp_an = 4'b1111 ^ (4'b0001 << d);
      total++;
      if (gap_an[d] !== 4'b1111 || gap_seg[d] !== 8'hFF ||
          an_cap[d] !== exp_an || seg_cap[d] !== exp_seg[d] || !stable[d]) begin
        bad++;
        $display("FAIL load_slot d%0d: gap=%b/%b an=%b seg=%b stable=%b, want gap=1111/11111111 an=%b seg=%b",
                 d, gap_an[d], gap_seg[d], an_cap[d], seg_cap[d], stable[d], exp_an, exp_seg[d]);
      end
    end
    total++;
    if (n_loaded - n0 !== 1 || loaded !== 1'b0) begin
      bad++;
      $display("FAIL load_single_pulse: pulses=%0d loaded=%b, want 1 0", n_loaded - n0, loaded);
    end
  endtask

  task automatic test_lzb();
    logic [15:0] v_bcd[3];
    logic [3:0]  v_dot[3];
    logic [0:7]  v_exp[3][4];
    v_bcd = '{16'h0050, 16'h0000, 16'h0007};
    v_dot = '{4'b0000, 4'b0000, 4'b0100};
    v_exp[0] = '{8'b0000001_1, 8'b0100100_1, 8'hFF, 8'hFF};
    v_exp[1] = '{8'b0000001_1, 8'hFF, 8'hFF, 8'hFF};
    v_exp[2] = '{8'b0001111_1, 8'b0000001_1, 8'b0000001_0, 8'hFF};
    for (int v = 0; v < 3; v++) begin
      do_load(v_bcd[v], v_dot[v], 4'b0000, 1'b1);
      wait_fs();
      capture_frame();
      for (int d = 0; d < 4; d++) begin
        exp_an = 4'b1111 ^ (4'b0001 << d);
        total++;
        if (an_cap[d] !== exp_an || seg_cap[d] !== v_exp[v][d] || !stable[d]) begin
          bad++;
          $display("FAIL lzb_v%0d d%0d: an=%b seg=%b stable=%b, want an=%b seg=%b",
                   v, d, an_cap[d], seg_cap[d], stable[d], exp_an, v_exp[v][d]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = n_loaded;
    do_load(16'h1111, 4'b0000, 4'b0000, 1'b0);
    step();
    do_load(16'h2222, 4'b0000, 4'b0000, 1'b0);
    wait_fs();
    capture_frame();
    for (int d = 0; d < 4; d++) begin
      total++;
      if (seg_cap[d] !== 8'b0010010_1) begin
        bad++;
        $display("FAIL b2b_last_wins d%0d: seg=%b, want 00100101", d, seg_cap[d]);
      end
    end
    total++;
    if (n_loaded - n0 !== 1) begin
      bad++;
      $display("FAIL b2b_one_pulse: pulses=%0d, want 1", n_loaded - n0);
    end
    // Load exactly in the commit-boundary cycle (15 cycles after frame_start)
    repeat (15) step();
    n0 = n_loaded;
    do_load(16'h3333, 4'b0000, 4'b0000, 1'b0);
    total++;
    if (frame_start !== 1'b1 || loaded !== 1'b1) begin
      bad++;
      $display("FAIL boundary_bypass_pulse: frame_start=%b loaded=%b, want 1 1", frame_start, loaded);
    end
    capture_frame();
    for (int d = 0; d < 4; d++) begin
      total++;
      if (seg_cap[d] !== 8'b0000110_1) begin
        bad++;
        $display("FAIL boundary_bypass d%0d: seg=%b, want 00001101", d, seg_cap[d]);
      end
    end
    total++;
    if (n_loaded - n0 !== 1 || loaded !== 1'b0) begin
      bad++;
      $display("FAIL boundary_no_repeat: pulses=%0d loaded=%b, want 1 0", n_loaded - n0, loaded);
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    do_load(16'h4444, 4'b0000, 4'b0000, 1'b0);
    repeat (9) step();
    total++;
    if (an !== 4'b1011 || seg !== 8'b0000110_1) begin
      bad++;
      $display("FAIL mid_digit2: an=%b seg=%b, want an=1011 seg=00001101", an, seg);
    end
    n0 = n_loaded;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (seg !== 8'hFF || an !== 4'b1111 || loaded !== 1'b0 || frame_start !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: seg=%b an=%b loaded=%b fs=%b, want 11111111 1111 0 0",
               seg, an, loaded, frame_start);
    end
    step();
    total++;
    if (an !== 4'b1111) begin
      bad++;
      $display("FAIL mid_restart_gap: an=%b, want 1111", an);
    end
    step();
    total++;
    if (an !== 4'b1110 || seg !== 8'hFF) begin
      bad++;
      $display("FAIL mid_restart_idx0: an=%b seg=%b, want 1110 11111111", an, seg);
    end
    wait_fs();
    total++;
    if (loaded !== 1'b0 || n_loaded !== n0) begin
      bad++;
      $display("FAIL mid_pending_dropped: loaded=%b pulses=%0d, want 0 0", loaded, n_loaded - n0);
    end
    capture_frame();
    for (int d = 0; d < 4; d++) begin
      exp_an = 4'b1111 ^ (4'b0001 << d);
      total++;
      if (an_cap[d] !== exp_an || seg_cap[d] !== 8'hFF) begin
        bad++;
        $display("FAIL mid_blank_frame d%0d: an=%b seg=%b, want an=%b seg=11111111",
                 d, an_cap[d], seg_cap[d], exp_an);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    load     = 1'b0;
    bcd_in   = '0;
    dot_in   = '0;
    blank_in = '0;
    lzb_en   = 1'b0;
    @(negedge clk);
    test_reset();
    test_load();
    test_lzb();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
